// File: rtl/cpu_wb_port_arbiter.sv
// cpu_wb_port_arbiter: shares the register-file write port between loads and ALU results, queuing ALU results that lose.
// Optional macro CPU_WBARB_FWD_EN adds a forwarding lookup over queued results and the writeback register.
module cpu_wb_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int REG_AW       = 5,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [REG_AW-1:0]        alu_rd,
    input  logic [XLEN-1:0]          alu_data,
    input  logic                     ld_valid,
    output logic                     ld_ready,
    input  logic [REG_AW-1:0]        ld_rd,
    input  logic [XLEN-1:0]          ld_data,
    output logic                     wb_en,
    output logic [REG_AW-1:0]        wb_rd,
    output logic [XLEN-1:0]          wb_data,
    output logic [$clog2(DEPTH):0]   q_count
`ifdef CPU_WBARB_FWD_EN
    ,
    input  logic [REG_AW-1:0]        fwd_rd,
    output logic                     fwd_hit,
    output logic [XLEN-1:0]          fwd_data
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [REG_AW-1:0] rd_mem_q [DEPTH];
    logic [REG_AW-1:0] rd_mem_d [DEPTH];
    logic [XLEN-1:0]   data_mem_q [DEPTH];
    logic [XLEN-1:0]   data_mem_d [DEPTH];
    logic [AW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic              wb_en_q, wb_en_d;
    logic [REG_AW-1:0] wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              empty, starve, pop, push, bypass, grant_ld, grant;
    logic [REG_AW-1:0] g_rd;
    logic [XLEN-1:0]   g_data;

    always_comb begin
        empty    = count_q == '0;
        starve   = !empty && starve_q == SW'(STARVE_LIMIT);
        pop      = !empty && (starve || !ld_valid);
        grant_ld = ld_valid && !starve;
        bypass   = empty && !ld_valid && alu_valid;
        // a full FIFO still accepts when its head leaves in the same cycle
        push     = alu_valid && !bypass && (count_q != CW'(DEPTH) || pop);
        grant    = pop || grant_ld || bypass;
        g_rd     = pop ? rd_mem_q[head_q] : grant_ld ? ld_rd : alu_rd;
        g_data   = pop ? data_mem_q[head_q] : grant_ld ? ld_data : alu_data;
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        if (push) begin
            rd_mem_d[tail_q]   = alu_rd;
            data_mem_d[tail_q] = alu_data;
        end
        head_d    = pop ? head_q + AW'(1) : head_q;
        tail_d    = push ? tail_q + AW'(1) : tail_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        starve_d  = (empty || pop) ? '0 : starve ? starve_q : starve_q + SW'(1);
        wb_en_d   = grant && g_rd != '0;
        wb_rd_d   = grant ? g_rd : wb_rd_q;
        wb_data_d = grant ? g_data : wb_data_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_mem_q   <= '{default: '0};
            data_mem_q <= '{default: '0};
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            wb_en_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            wb_en_q    <= wb_en_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign alu_ready = bypass || push;
    assign ld_ready  = grant_ld;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign q_count   = count_q;

`ifdef CPU_WBARB_FWD_EN
    // scan oldest to youngest so the last match wins; wb_* is older than any queued entry
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (fwd_rd != '0 && wb_en_q && wb_rd_q == fwd_rd) begin
            fwd_hit  = 1'b1;
            fwd_data = wb_data_q;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (fwd_rd != '0 && CW'(i) < count_q && rd_mem_q[head_q + AW'(i)] == fwd_rd) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[head_q + AW'(i)];
            end
        end
    end
`endif
endmodule

// File: tb/tb_cpu_wb_port_arbiter.sv
// tb_cpu_wb_port_arbiter: randomized and directed checks of the writeback arbiter against a queue-based reference model.
module tb_cpu_wb_port_arbiter;
    localparam int XLEN = 32, REG_AW = 5, DEPTH = 4, STARVE_LIMIT = 3;
    localparam int CW = $clog2(DEPTH) + 1;

    logic clock = 1'b0;
    logic reset;
    logic alu_valid, alu_ready, ld_valid, ld_ready, wb_en;
    logic [REG_AW-1:0] alu_rd, ld_rd, wb_rd;
    logic [XLEN-1:0] alu_data, ld_data, wb_data;
    logic [CW-1:0] q_count;
`ifdef CPU_WBARB_FWD_EN
    logic [REG_AW-1:0] fwd_rd = '0;
    logic fwd_hit;
    logic [XLEN-1:0] fwd_data;
`endif

    always #5 clock = ~clock;

    cpu_wb_port_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clock(clock), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .q_count(q_count)
`ifdef CPU_WBARB_FWD_EN
        , .fwd_rd(fwd_rd), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
`endif
    );

    int vectors = 0, miscompares = 0;
    logic [REG_AW+XLEN-1:0] mq[$];
    int mstarve = 0;
    logic e_ar, e_lr, e_en;
    logic [REG_AW-1:0] e_rd = '0;
    logic [XLEN-1:0] e_data = '0;
    logic [CW-1:0] e_cnt;

    // Applies one cycle of inputs and predicts this cycle's readies and the next wb_*/q_count.
    task automatic cycle(input logic av, input logic [REG_AW-1:0] ar, input logic [XLEN-1:0] ad,
                         input logic lv, input logic [REG_AW-1:0] lr, input logic [XLEN-1:0] ld);
        logic empty, starve, pop, byp, push, grant;
        logic [REG_AW+XLEN-1:0] item;
        alu_valid = av; alu_rd = ar; alu_data = ad;
        ld_valid = lv; ld_rd = lr; ld_data = ld;
        empty  = mq.size() == 0;
        starve = !empty && mstarve == STARVE_LIMIT;
        pop    = !empty && (starve || !lv);
        e_lr   = lv && !starve;
        byp    = empty && !lv && av;
        push   = av && !byp && (mq.size() < DEPTH || pop);
        e_ar   = byp || push;
        grant  = pop || e_lr || byp;
        item   = pop ? mq[0] : e_lr ? {lr, ld} : {ar, ad};
        e_en   = grant && item[REG_AW+XLEN-1:XLEN] != '0;
        if (grant) begin
            e_rd   = item[REG_AW+XLEN-1:XLEN];
            e_data = item[XLEN-1:0];
        end
        mstarve = (empty || pop) ? 0 : (mstarve < STARVE_LIMIT ? mstarve + 1 : STARVE_LIMIT);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({ar, ad});
        e_cnt = CW'(mq.size());
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        alu_valid = 0; ld_valid = 0; alu_rd = '0; ld_rd = '0; alu_data = '0; ld_data = '0;
        reset = 1'b1;
        #1;
        vectors++;
        if (wb_en !== 1'b0 || wb_rd !== '0 || wb_data !== '0 || q_count !== '0) begin
            miscompares++;
            $display("FAIL reset_init: got en=%b rd=%0d data=%h cnt=%0d want 0 0 0 0", wb_en, wb_rd, wb_data, q_count);
        end
        #11 reset = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            cycle(1, REG_AW'(i + 1), $urandom, 1, REG_AW'(i + 20), $urandom);
            tick();
        end
        vectors++;
        if (q_count !== 3'd3) begin
            miscompares++;
            $display("FAIL reset_prefill: got cnt=%0d want 3", q_count);
        end
        #2 reset = 1'b1;
        mq.delete(); mstarve = 0;
        alu_valid = 0; ld_valid = 0;
        #1;
        vectors++;
        if (wb_en !== 1'b0 || q_count !== '0) begin
            miscompares++;
            $display("FAIL reset_async: got en=%b cnt=%0d want en=0 cnt=0", wb_en, q_count);
        end
        #10 reset = 1'b0;
        tick();
        cycle(1, 5'd5, 32'h11, 0, '0, '0);
        tick();
        vectors++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 32'h11 || q_count !== '0) begin
            miscompares++;
            $display("FAIL reset_first: got en=%b rd=%0d data=%h cnt=%0d want 1 5 11 0", wb_en, wb_rd, wb_data, q_count);
        end
    endtask

    task automatic test_bypass();
        cycle(1, 5'd7, 32'hA5A5, 0, '0, '0);
        vectors++;
        if (alu_ready !== 1'b1 || ld_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bypass_ready: got alu=%b ld=%b want 1 0", alu_ready, ld_ready);
        end
        tick();
        alu_valid = 0;
        vectors++;
        if (wb_en !== 1'b1 || wb_rd !== 5'd7 || wb_data !== 32'hA5A5 || q_count !== '0) begin
            miscompares++;
            $display("FAIL bypass_wb: got en=%b rd=%0d data=%h cnt=%0d want 1 7 a5a5 0", wb_en, wb_rd, wb_data, q_count);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 7; i++) begin
            cycle(1, REG_AW'(i + 1), $urandom, 1, REG_AW'(i + 20), $urandom);
            vectors++;
            if (alu_ready !== e_ar || ld_ready !== e_lr) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: got alu=%b ld=%b want alu=%b ld=%b", i, alu_ready, ld_ready, e_ar, e_lr);
            end
            tick();
            vectors++;
            if (wb_en !== e_en || (e_en && (wb_rd !== e_rd || wb_data !== e_data)) || q_count !== e_cnt) begin
                miscompares++;
                $display("FAIL fill_wb[%0d]: got en=%b rd=%0d data=%h cnt=%0d want en=%b rd=%0d data=%h cnt=%0d",
                         i, wb_en, wb_rd, wb_data, q_count, e_en, e_rd, e_data, e_cnt);
            end
        end
    endtask

    task automatic test_drain();
        for (int g = 0; g < 20 && mq.size() > 0; g++) begin
            cycle(0, '0, '0, 0, '0, '0);
            vectors++;
            if (alu_ready !== e_ar || ld_ready !== e_lr) begin
                miscompares++;
                $display("FAIL drain_ready: got alu=%b ld=%b want alu=%b ld=%b", alu_ready, ld_ready, e_ar, e_lr);
            end
            tick();
            vectors++;
            if (wb_en !== e_en || (e_en && (wb_rd !== e_rd || wb_data !== e_data)) || q_count !== e_cnt) begin
                miscompares++;
                $display("FAIL drain_wb: got en=%b rd=%0d data=%h cnt=%0d want en=%b rd=%0d data=%h cnt=%0d",
                         wb_en, wb_rd, wb_data, q_count, e_en, e_rd, e_data, e_cnt);
            end
        end
    endtask

    task automatic test_starvation();
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, 5'd3, 32'h333, 1, REG_AW'(i + 10), $urandom);
            vectors++;
            if (alu_ready !== e_ar || ld_ready !== e_lr || (i >= 1 && i <= 3 && ld_ready !== 1'b1) || (i == 4 && ld_ready !== 1'b0)) begin
                miscompares++;
                $display("FAIL starve_ready[%0d]: got alu=%b ld=%b want alu=%b ld=%b", i, alu_ready, ld_ready, e_ar, e_lr);
            end
            tick();
            vectors++;
            if (wb_en !== e_en || (e_en && (wb_rd !== e_rd || wb_data !== e_data)) || q_count !== e_cnt
                || (i == 4 && wb_rd !== 5'd3)) begin
                miscompares++;
                $display("FAIL starve_wb[%0d]: got en=%b rd=%0d data=%h cnt=%0d want en=%b rd=%0d data=%h cnt=%0d",
                         i, wb_en, wb_rd, wb_data, q_count, e_en, e_rd, e_data, e_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        for (int i = -1; i < 10; i++) begin
            cycle(1, (i == 5) ? '0 : REG_AW'(i + 2), $urandom, i < 0, 5'd30, $urandom);
            vectors++;
            if (alu_ready !== e_ar || ld_ready !== e_lr) begin
                miscompares++;
                $display("FAIL wrap_ready[%0d]: got alu=%b ld=%b want alu=%b ld=%b", i, alu_ready, ld_ready, e_ar, e_lr);
            end
            tick();
            vectors++;
            if (wb_en !== e_en || (e_en && (wb_rd !== e_rd || wb_data !== e_data)) || q_count !== e_cnt) begin
                miscompares++;
                $display("FAIL wrap_wb[%0d]: got en=%b rd=%0d data=%h cnt=%0d want en=%b rd=%0d data=%h cnt=%0d",
                         i, wb_en, wb_rd, wb_data, q_count, e_en, e_rd, e_data, e_cnt);
            end
        end
    endtask

`ifdef CPU_WBARB_FWD_EN
    task automatic test_fwd();
        cycle(1, 5'd9, 32'd1, 1, 5'd4, 32'h40);
        tick();
        cycle(1, 5'd9, 32'd2, 1, 5'd4, 32'h41);
        tick();
        cycle(0, '0, '0, 1, 5'd4, 32'h42);
        fwd_rd = 5'd9;
        #1;
        vectors++;
        if (fwd_hit !== 1'b1 || fwd_data !== 32'd2) begin
            miscompares++;
            $display("FAIL fwd_hit: got hit=%b data=%h want 1 2", fwd_hit, fwd_data);
        end
        fwd_rd = '0;
        #1;
        vectors++;
        if (fwd_hit !== 1'b0) begin
            miscompares++;
            $display("FAIL fwd_x0: got hit=%b want 0", fwd_hit);
        end
        tick();
        vectors++;
        if (wb_en !== e_en || q_count !== e_cnt) begin
            miscompares++;
            $display("FAIL fwd_wb: got en=%b cnt=%0d want en=%b cnt=%0d", wb_en, q_count, e_en, e_cnt);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1) == 1, REG_AW'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 2) == 0, REG_AW'($urandom_range(0, 31)), $urandom);
            vectors++;
            if (alu_ready !== e_ar || ld_ready !== e_lr) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got alu=%b ld=%b want alu=%b ld=%b", i, alu_ready, ld_ready, e_ar, e_lr);
            end
            tick();
            vectors++;
            if (wb_en !== e_en || (e_en && (wb_rd !== e_rd || wb_data !== e_data)) || q_count !== e_cnt) begin
                miscompares++;
                $display("FAIL rand_wb[%0d]: got en=%b rd=%0d data=%h cnt=%0d want en=%b rd=%0d data=%h cnt=%0d",
                         i, wb_en, wb_rd, wb_data, q_count, e_en, e_rd, e_data, e_cnt);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_bypass();
        test_fill();
        test_drain();
        test_starvation();
        test_drain();
        test_wrap();
        test_drain();
`ifdef CPU_WBARB_FWD_EN
        test_fwd();
        test_drain();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
